// File: rtl/urv_divide_pkg.sv
// Shared definitions for the RV32M iterative divider: funct3 codes, FSM states, helpers.
// The optional early-out path is enabled by defining URV_DIV_EARLY_OUT_EN.
package urv_divide_pkg;

    localparam int unsigned XLen = 32;

    localparam logic [2:0] FunDiv  = 3'b100;
    localparam logic [2:0] FunDivu = 3'b101;
    localparam logic [2:0] FunRem  = 3'b110;
    localparam logic [2:0] FunRemu = 3'b111;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StDivide = 3'd2,
        StFixup  = 3'd3,
        StDone   = 3'd4
    } div_state_e;

    function automatic logic fun_is_unsigned(input logic [2:0] fun);
        return (fun == FunDivu) || (fun == FunRemu);
    endfunction

    function automatic logic fun_is_rem(input logic [2:0] fun);
        return (fun == FunRem) || (fun == FunRemu);
    endfunction

    // Architectural results for divide-by-zero and signed overflow.
    function automatic logic [XLen-1:0] special_result(input logic            is_rem,
                                                       input logic            div_zero,
                                                       input logic [XLen-1:0] dividend);
        if (div_zero) begin
            return is_rem ? dividend : {XLen{1'b1}};
        end
        return is_rem ? {XLen{1'b0}} : {1'b1, {(XLen-1){1'b0}}};
    endfunction

endpackage

// File: rtl/urv_div_step.sv
// One restoring radix-2 division step: trial subtract of the divisor from the
// shifted partial remainder, producing the next remainder and the quotient bit.
module urv_div_step
    import urv_divide_pkg::*;
(
    input  logic [XLen-1:0] rem_i,
    input  logic            q_msb_i,
    input  logic [XLen-1:0] divisor_i,
    output logic [XLen-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLen:0] shifted;
    logic [XLen:0] diff;

    always_comb begin
        shifted = {rem_i, q_msb_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[XLen];
        // The remainder is always below the divisor, so it fits back into XLen bits.
        rem_o   = q_bit_o ? diff[XLen-1:0] : shifted[XLen-1:0];
    end

endmodule

// File: rtl/urv_divide.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), fixed 35-cycle latency.
// Define URV_DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow straight from SETUP.
module urv_divide
    import urv_divide_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            d_start_i,
    input  logic [XLen-1:0] d_rs1_i,
    input  logic [XLen-1:0] d_rs2_i,
    input  logic [2:0]      d_fun_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    output logic            busy_o,
    output logic            w_valid_o,
    output logic [XLen-1:0] w_rd_o
);

`ifdef URV_DIV_EARLY_OUT_EN
    localparam bit EarlyOutEn = 1'b1;
`else
    localparam bit EarlyOutEn = 1'b0;
`endif

    div_state_e      state_q, state_d;
    logic [XLen-1:0] a_q, a_d;
    logic [XLen-1:0] b_q, b_d;
    logic [2:0]      fun_q, fun_d;
    logic [XLen-1:0] quo_q, quo_d;
    logic [XLen-1:0] rem_q, rem_d;
    logic [XLen-1:0] dvs_q, dvs_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [XLen-1:0] w_rd_q, w_rd_d;

    logic            is_signed, is_rem, a_neg, b_neg, div_zero, sgn_ovf;
    logic [XLen-1:0] a_abs, b_abs, step_rem, result;
    logic            step_bit;

    urv_div_step u_step (
        .rem_i     (rem_q),
        .q_msb_i   (quo_q[XLen-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    always_comb begin
        is_signed = ~fun_is_unsigned(fun_q);
        is_rem    = fun_is_rem(fun_q);
        a_neg     = is_signed & a_q[XLen-1];
        b_neg     = is_signed & b_q[XLen-1];
        a_abs     = a_neg ? -a_q : a_q;
        b_abs     = b_neg ? -b_q : b_q;
        div_zero  = (b_q == '0);
        sgn_ovf   = is_signed && (a_q == {1'b1, {(XLen-1){1'b0}}}) && (b_q == '1);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        w_rd_d  = w_rd_q;
        result  = '0;

        unique case (state_q)
            StIdle: begin
                if (d_start_i) begin
                    a_d     = d_rs1_i;
                    b_d     = d_rs2_i;
                    fun_d   = d_fun_i;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                quo_d   = a_abs;
                dvs_d   = b_abs;
                rem_d   = '0;
                cnt_d   = 5'd31;
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
                dz_d    = div_zero;
                ovf_d   = sgn_ovf;
                state_d = StDivide;
                if (EarlyOutEn && (div_zero || sgn_ovf)) begin
                    w_rd_d  = special_result(is_rem, div_zero, a_q);
                    state_d = StDone;
                end
            end
            StDivide: begin
                rem_d = step_rem;
                quo_d = {quo_q[XLen-2:0], step_bit};
                if (cnt_q == 5'd0) begin
                    state_d = StFixup;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StFixup: begin
                if (is_rem) begin
                    result = negr_q ? -rem_q : rem_q;
                end else begin
                    result = negq_q ? -quo_q : quo_q;
                end
                // Unreachable with early-out, where SETUP already resolved these cases.
                if (dz_q || ovf_q) begin
                    result = special_result(is_rem, dz_q, a_q);
                end
                w_rd_d  = result;
                state_d = StDone;
            end
            StDone: begin
                if (!x_stall_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A flush drops any in-flight or same-cycle operation and leaves the last result intact.
        if (x_kill_i) begin
            state_d = StIdle;
            w_rd_d  = w_rd_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            w_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            w_rd_q  <= w_rd_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign w_valid_o = (state_q == StDone);
    assign w_rd_o    = w_rd_q;

endmodule

// File: tb/tb_urv_divide.sv
// Self-checking bench for urv_divide: RV32M reference model, per-cycle output compare,
// directed corner cases and randomized operations with stalls and kills.
module tb_urv_divide;

`ifdef URV_DIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        d_start_i = 1'b0;
    logic [31:0] d_rs1_i = '0;
    logic [31:0] d_rs2_i = '0;
    logic [2:0]  d_fun_i = 3'b100;
    logic        x_stall_i = 1'b0;
    logic        x_kill_i = 1'b0;
    logic        busy_o, w_valid_o;
    logic [31:0] w_rd_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    urv_divide dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .d_start_i (d_start_i),
        .d_rs1_i   (d_rs1_i),
        .d_rs2_i   (d_rs2_i),
        .d_fun_i   (d_fun_i),
        .x_stall_i (x_stall_i),
        .x_kill_i  (x_kill_i),
        .busy_o    (busy_o),
        .w_valid_o (w_valid_o),
        .w_rd_o    (w_rd_o)
    );

    always #5 clk_i = ~clk_i;

    // RV32M semantics: funct3[0]=unsigned, funct3[1]=remainder.
    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (EarlyOut && special) ? 2 : 35;
    endfunction

    // Timeline model: idle / computing (age counts cycles since launch) / result held.
    int          m_phase = 0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_rd = '0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_phase <= 0;
            m_age   <= 0;
            m_rd    <= '0;
        end else if (x_kill_i) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (d_start_i) begin
                    m_phase <= 1;
                    m_age   <= 1;
                    m_res   <= ref_div(d_fun_i, d_rs1_i, d_rs2_i);
                    m_lat   <= ref_lat(d_fun_i, d_rs1_i, d_rs2_i);
                end
                1: begin
                    m_age <= m_age + 1;
                    if (m_age + 1 == m_lat) begin
                        m_phase <= 2;
                        m_rd    <= m_res;
                    end
                end
                default: if (!x_stall_i) m_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int sc, input bit poke,
                          output logic [31:0] got);
        logic [31:0] exp;
        int lat;
        exp       = ref_div(f, a, b);
        d_fun_i   = f;
        d_rs1_i   = a;
        d_rs2_i   = b;
        d_start_i = 1'b1;
        x_stall_i = (sc > 0);
        tick;
        d_start_i = 1'b0;
        lat = 1;
        while (!w_valid_o && lat < 100) begin
            tick;
            lat++;
        end
        got = w_rd_o;
        chk({name, "_latency"}, lat, ref_lat(f, a, b));
        chk({name, "_rd"}, w_rd_o, exp);
        for (int i = 0; i < sc; i++) begin
            if (poke) begin
                d_start_i = 1'b1;
                d_rs1_i   = $urandom;
                d_fun_i   = 3'b101;
            end
            tick;
            chk({name, "_hold_valid"}, w_valid_o, 1);
            chk({name, "_hold_rd"}, w_rd_o, exp);
        end
        d_start_i = 1'b0;
        x_stall_i = 1'b0;
        tick;
        chk({name, "_release_valid"}, w_valid_o, 0);
        chk({name, "_release_busy"}, busy_o, 0);
    endtask

    initial begin
        logic [31:0] got, a, b;
        logic [2:0]  f;
        int seen, k;

        fork
            forever begin
                @(negedge clk_i);
                if (chk_en) begin
                    chk("cyc_busy", busy_o, m_phase != 0);
                    chk("cyc_valid", w_valid_o, m_phase == 2);
                    chk("cyc_rd", w_rd_o, m_rd);
                end
            end
        join_none

        tick;
        tick;
        rst_i  = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", busy_o, 0);
        chk("reset_valid", w_valid_o, 0);
        chk("reset_rd", w_rd_o, 0);

        // Pin the model against hand-computed values.
        chk("model_divu", ref_div(3'b101, 32'd100, 32'd7), 32'd14);
        chk("model_rem_neg", ref_div(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_div0", ref_div(3'b100, 32'h1234, 32'd0), 32'hFFFF_FFFF);

        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 0, 0, got);
        chk("divu_100_7_lit", got, 32'd14);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 0, 0, got);
        chk("remu_100_7_lit", got, 32'd2);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 0, 0, got);
        chk("div_m7_2_lit", got, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 0, 0, got);
        chk("rem_m7_2_lit", got, 32'hFFFF_FFFF);
        run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 0, 0, got);
        chk("rem_7_m2_lit", got, 32'd1);
        run_op("div_by0", 3'b100, 32'h1234, 32'd0, 0, 0, got);
        chk("div_by0_lit", got, 32'hFFFF_FFFF);
        run_op("remu_by0", 3'b111, 32'h1234, 32'd0, 0, 0, got);
        chk("remu_by0_lit", got, 32'h1234);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, got);
        chk("div_ovf_lit", got, 32'h8000_0000);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, got);
        chk("rem_ovf_lit", got, 32'd0);

        // Kill at n+10.
        d_fun_i = 3'b101; d_rs1_i = 32'd1000; d_rs2_i = 32'd3; d_start_i = 1'b1;
        tick;
        d_start_i = 1'b0;
        repeat (9) tick;
        x_kill_i = 1'b1;
        tick;
        x_kill_i = 1'b0;
        chk("kill_busy", busy_o, 0);
        chk("kill_valid", w_valid_o, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (w_valid_o) seen++;
        end
        chk("kill_no_valid", seen, 0);
        run_op("divu_max_3", 3'b101, 32'hFFFF_FFFF, 32'd3, 0, 0, got);
        chk("divu_max_3_lit", got, 32'h5555_5555);

        // Start in the same cycle as a kill is dropped.
        d_start_i = 1'b1; x_kill_i = 1'b1;
        tick;
        d_start_i = 1'b0; x_kill_i = 1'b0;
        chk("start_kill_dropped", busy_o, 0);

        // Stall in DONE for 4 cycles with starts poked in, which must be ignored.
        run_op("stall4", 3'b100, 32'd12345, 32'hFFFF_FFF6, 4, 1, got);
        chk("stall4_lit", got, 32'hFFFF_FB2E);

        // Reset at n+20.
        d_fun_i = 3'b101; d_rs1_i = 32'd99; d_rs2_i = 32'd5; d_start_i = 1'b1;
        tick;
        d_start_i = 1'b0;
        repeat (19) tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", w_valid_o, 0);
        chk("midrst_rd", w_rd_o, 0);

        for (int t = 0; t < 150; t++) begin
            f = {1'b1, 2'($urandom_range(0, 3))};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = $urandom_range(0, 15) - 8;
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                d_fun_i = f; d_rs1_i = a; d_rs2_i = b; d_start_i = 1'b1; x_stall_i = 1'b1;
                tick;
                d_start_i = 1'b0;
                k = $urandom_range(1, 37);
                repeat (k) tick;
                x_kill_i = 1'b1;
                tick;
                x_kill_i  = 1'b0;
                x_stall_i = 1'b0;
                chk("rnd_kill_busy", busy_o, 0);
            end else begin
                run_op("rnd", f, a, b, $urandom_range(0, 3), 0, got);
            end
        end

        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
